// File: rtl/shift_engine_pkg.sv
// rtl/shift_engine_pkg.sv - mode codes, FSM states and direction helper for the shift engine
package shift_engine_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ASR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_left(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_ROL);
  endfunction

  function automatic logic is_right(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_ROR) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - enabled register with selectable reset style and polarity
module dff #(
  parameter int WIDTH          = 1,
  parameter bit ASYNC_RESET    = 1'b1,
  parameter bit RESET_POLARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (ASYNC_RESET && !RESET_POLARITY) begin : g_async_low
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
      end
    end else if (ASYNC_RESET) begin : g_async_high
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (rst == RESET_POLARITY) q <= '0;
        else if (en)               q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one lane step of the shift datapath; unused mode codes hold
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANE  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [LANE-1:0]  sin_lsb,
  input  logic [LANE-1:0]  sin_msb,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_SHL: next_q = {q[WIDTH-LANE-1:0], sin_lsb};
      MODE_SHR: next_q = {sin_msb, q[WIDTH-1:LANE]};
      MODE_ROL: next_q = {q[WIDTH-LANE-1:0], q[WIDTH-1:WIDTH-LANE]};
      MODE_ROR: next_q = {q[LANE-1:0], q[WIDTH-1:LANE]};
      MODE_ASR: next_q = {{LANE{q[WIDTH-1]}}, q[WIDTH-1:LANE]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_engine.sv
// rtl/universal_shift_engine.sv - counted lane-step shift register with load handshake and done pulse
module universal_shift_engine
  import shift_engine_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANE  = 1,
  localparam int CNT_W = $clog2(WIDTH/LANE) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  input  logic [LANE-1:0]  i_sin_lsb,
  input  logic [LANE-1:0]  i_sin_msb,
  output logic [WIDTH-1:0] o_q,
  output logic [LANE-1:0]  o_sout,
  output logic             o_busy,
  output logic             o_done
);

  state_t           state_q, state_d;
  logic [2:0]       mode_q;
  logic             left_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch;
  logic             q_en;
  logic [WIDTH-1:0] q_d, step_q;

  shift_step #(.WIDTH(WIDTH), .LANE(LANE)) u_step (
    .q       (o_q),
    .mode    (mode_q),
    .sin_lsb (i_sin_lsb),
    .sin_msb (i_sin_msb),
    .next_q  (step_q)
  );

  dff #(.WIDTH(WIDTH), .ASYNC_RESET(1'b1), .RESET_POLARITY(1'b0)) u_q_reg (
    .clk (i_clk),
    .rst (i_rst),
    .en  (q_en),
    .d   (q_d),
    .q   (o_q)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // HOLD-class modes leave the serial-out direction where the last real shift put it
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q <= MODE_HOLD;
      left_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (latch) begin
        mode_q <= i_mode;
        if (is_left(i_mode))       left_q <= 1'b1;
        else if (is_right(i_mode)) left_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_en    = 1'b0;
    q_d     = o_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_load_valid) begin
          q_en = 1'b1;
          q_d  = i_load;
        end else if (i_start) begin
          latch   = 1'b1;
          cnt_d   = i_count;
          state_d = (i_count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          q_en  = 1'b1;
          q_d   = step_q;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_load_ready = (state_q == ST_IDLE);
  assign o_busy       = (state_q == ST_SHIFT);
  assign o_done       = (state_q == ST_DONE);
  assign o_sout       = left_q ? o_q[WIDTH-1 -: LANE] : o_q[LANE-1:0];

endmodule

// File: tb/tb_universal_shift_engine.sv
// tb/tb_universal_shift_engine.sv - directed and randomized checks of the shift engine against an arithmetic model
module tb_universal_shift_engine;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_load_d, a_q;
  logic       a_load_valid, a_load_ready, a_start, a_abort, a_busy, a_done;
  logic [2:0] a_mode;
  logic [3:0] a_count;
  logic       a_sin_lsb, a_sin_msb, a_sout;

  logic [7:0] b_load_d, b_q;
  logic       b_load_valid, b_load_ready, b_start, b_abort, b_busy, b_done;
  logic [2:0] b_mode;
  logic [1:0] b_count;
  logic [3:0] b_sin_lsb, b_sin_msb, b_sout;

  int          checks;
  int          failures;
  int unsigned mq;
  bit          mdir;

  universal_shift_engine #(.WIDTH(8), .LANE(1)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_load(a_load_d), .i_load_valid(a_load_valid),
    .o_load_ready(a_load_ready), .i_start(a_start), .i_mode(a_mode), .i_count(a_count),
    .i_abort(a_abort), .i_sin_lsb(a_sin_lsb), .i_sin_msb(a_sin_msb), .o_q(a_q),
    .o_sout(a_sout), .o_busy(a_busy), .o_done(a_done)
  );

  universal_shift_engine #(.WIDTH(8), .LANE(4)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_load(b_load_d), .i_load_valid(b_load_valid),
    .o_load_ready(b_load_ready), .i_start(b_start), .i_mode(b_mode), .i_count(b_count),
    .i_abort(b_abort), .i_sin_lsb(b_sin_lsb), .i_sin_msb(b_sin_msb), .o_q(b_q),
    .o_sout(b_sout), .o_busy(b_busy), .o_done(b_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Register treated as an integer in [0, 2**w); one step is scale/divide by 2**l
  function automatic int unsigned mstep(input int w, input int l, input int mode,
                                        input int unsigned q, input int unsigned sl,
                                        input int unsigned sr);
    int unsigned m, full, top;
    m = 1 << l; full = 1 << w; top = full / m;
    case (mode)
      1: return (q * m + sl) % full;
      2: return q / m + sr * top;
      3: return (q * m) % full + q / top;
      4: return q / m + (q % m) * top;
      5: return q / m + ((q >= full / 2) ? (m - 1) * top : 0);
      default: return q;
    endcase
  endfunction

  task automatic a_do_load(input int unsigned v);
    a_load_d = v[7:0]; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    mq = v;
    check("load_q", a_q, mq);
  endtask

  // abort_at < 0: no abort; sin_fixed < 0: random serial fill every step
  task automatic a_run(input int mode, input int cnt, input int abort_at, input int sin_fixed);
    int unsigned sl, sr;
    a_mode = mode[2:0]; a_count = cnt[3:0]; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    if (mode == 1 || mode == 3) mdir = 1'b1;
    else if (mode == 2 || mode == 4 || mode == 5) mdir = 1'b0;
    if (cnt == 0) begin
      check("zero_done", a_done, 1);
      check("zero_busy", a_busy, 0);
      check("zero_q", a_q, mq);
      tick();
      check("zero_done_end", a_done, 0);
      check("zero_ready", a_load_ready, 1);
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      check("busy", a_busy, 1);
      check("load_ready_busy", a_load_ready, 0);
      check("sout", a_sout, mdir ? (mq >> 7) : (mq & 1));
      sl = (sin_fixed < 0) ? $urandom_range(0, 1) : sin_fixed;
      sr = (sin_fixed < 0) ? $urandom_range(0, 1) : sin_fixed;
      a_sin_lsb = sl[0]; a_sin_msb = sr[0];
      a_load_valid = $urandom_range(0, 1) == 1;
      a_load_d = $urandom_range(0, 255);
      a_start = $urandom_range(0, 1) == 1;
      a_mode = $urandom_range(0, 7);
      if (k == abort_at) begin
        a_load_valid = 1'b0; a_start = 1'b0; a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_ready", a_load_ready, 1);
        check("abort_q", a_q, mq);
        tick();
        check("abort_no_done", a_done, 0);
        return;
      end
      tick();
      mq = mstep(8, 1, mode, mq, sl, sr);
      check("step_q", a_q, mq);
    end
    a_load_valid = 1'b0; a_start = 1'b0;
    check("end_busy", a_busy, 0);
    check("done", a_done, 1);
    check("done_ready", a_load_ready, 0);
    tick();
    check("done_pulse_end", a_done, 0);
    check("idle_ready", a_load_ready, 1);
    check("idle_q", a_q, mq);
  endtask

  initial begin
    checks = 0; failures = 0; mq = 0; mdir = 1'b1;
    clk = 1'b0; rst_n = 1'b0;
    a_load_d = '0; a_load_valid = 0; a_start = 0; a_abort = 0; a_mode = '0; a_count = '0;
    a_sin_lsb = 0; a_sin_msb = 0;
    b_load_d = '0; b_load_valid = 0; b_start = 0; b_abort = 0; b_mode = '0; b_count = '0;
    b_sin_lsb = '0; b_sin_msb = '0;
    #12;
    check("rst_q", a_q, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_load_ready, 1);
    check("rst_b_q", b_q, 0);
    rst_n = 1'b1;
    tick();

    a_do_load(8'hA5);
    a_run(3, 3, -1, -1);
    check("rol_final", a_q, 8'h2D);

    a_do_load(8'h90);
    a_run(5, 2, -1, -1);
    check("asr_final", a_q, 8'hE4);

    a_do_load(8'h00);
    a_run(1, 9, -1, 1);
    check("shl_sat_q", a_q, 8'hFF);
    check("shl_sat_sout", a_sout, 1);

    a_do_load(8'h01);
    a_run(4, 5, 2, -1);
    check("ror_abort_q", a_q, 8'h40);

    a_do_load(8'h37);
    a_run(0, 0, -1, -1);
    a_run(7, 4, -1, -1);
    check("hold_code7_q", a_q, 8'h37);

    for (int i = 0; i < 10; i++) begin
      a_do_load($urandom_range(0, 255));
      a_run($urandom_range(0, 7), $urandom_range(0, 12), -1, -1);
    end

    b_load_d = 8'h3C; b_load_valid = 1'b1;
    tick();
    b_load_valid = 1'b0;
    b_mode = 3'd4; b_count = 2'd1; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_busy", b_busy, 1);
    check("b_sout_pre", b_sout, 4'hC);
    tick();
    check("b_ror_q", b_q, 8'hC3);
    check("b_done", b_done, 1);
    tick();
    b_start = 1'b1; b_load_valid = 1'b1; b_load_d = 8'h11;
    tick();
    b_start = 1'b0; b_load_valid = 1'b0;
    check("b_load_wins_q", b_q, 8'h11);
    check("b_load_wins_busy", b_busy, 0);
    tick();
    check("b_start_dropped", b_busy, 0);
    check("b_start_dropped_q", b_q, 8'h11);

    a_do_load(8'h5A);
    a_mode = 3'd1; a_count = 4'd5; a_start = 1'b1; a_sin_lsb = 1'b0;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", a_q, 0);
    check("async_rst_busy", a_busy, 0);
    check("async_rst_done", a_done, 0);
    check("async_rst_ready", a_load_ready, 1);
    rst_n = 1'b1;
    mq = 0; mdir = 1'b1;
    tick();
    check("post_rst_done", a_done, 0);
    check("post_rst_q", a_q, 0);
    check("post_rst_busy", a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
